// File: rtl/rr_mux_pkg.sv
// Shared constants, lock-state type and select-width helper for the round-robin channel mux.
package rr_mux_pkg;

   localparam int unsigned MODE_SELECT = 0;
   localparam int unsigned MODE_RR     = 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   // Channel index width; a two-or-fewer channel mux still needs one select bit
   function automatic int unsigned sel_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational find-first over a request vector, searching upward from a start index with wrap.
module rr_priority_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   int unsigned cand;

   // Walk start, start+1, ... modulo N and keep the first requester seen
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = 0;
      for (int unsigned j = 0; j < N; j++) begin
         cand = (32'(start) + j) % N;
         if (!found && req[cand]) begin
            found = 1'b1;
            index = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rr_channel_mux.sv
// Registered N:1 channel mux with valid/ready, explicit-select or round-robin grant,
// and packet locking in round-robin mode.
module rr_channel_mux
   import rr_mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = MODE_SELECT,
   localparam int unsigned SEL_W   = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_last,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_last,
   output logic [SEL_W-1:0]          out_chan,
   input  logic                      out_ready
);

   logic             load_en;
   logic             grant;
   logic             xfer;
   logic [SEL_W-1:0] winner;
   logic [WIDTH-1:0] pick_data;
   logic             pick_last;

   lock_state_e      state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] lock_chan_q, lock_chan_d;

   if (MODE == MODE_RR) begin : g_rr
      logic [CHANNELS-1:0] eligible;
      logic                unused_sel;

      assign unused_sel = ^sel;

      // While a packet is in flight only its owning channel may compete
      always_comb begin
         eligible = in_valid;
         if (state_q == LOCKED) begin
            eligible = in_valid & (CHANNELS'(1) << lock_chan_q);
         end
      end

      rr_priority_picker #(
         .N     (CHANNELS),
         .IDX_W (SEL_W)
      ) u_picker (
         .req   (eligible),
         .start (ptr_q),
         .found (grant),
         .index (winner)
      );
   end else begin : g_sel
      // Explicit select: out-of-range sel never matches a channel, so no grant
      always_comb begin
         grant  = 1'b0;
         winner = sel;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
               grant = 1'b1;
            end
         end
      end
   end

   // Ready goes only to the winner, and only when the output register can take a word
   always_comb begin
      load_en  = !out_valid || out_ready;
      in_ready = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         in_ready[i] = !reset && load_en && grant && (winner == SEL_W'(i));
      end
      xfer = !reset && load_en && grant;
   end

   // Steer the winning channel's beat to the output register inputs
   always_comb begin
      pick_data = '0;
      pick_last = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (winner == SEL_W'(i)) begin
            pick_data = in_data[i*WIDTH +: WIDTH];
            pick_last = in_last[i];
         end
      end
   end

   // Lock state, round-robin pointer and owning channel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         lock_chan_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_chan_q <= lock_chan_d;
      end
   end

   // End of packet releases the lock and moves priority past the sender
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_chan_d = lock_chan_q;
      if (MODE == MODE_RR && xfer) begin
         if (pick_last) begin
            state_d = IDLE;
            ptr_d   = (winner == SEL_W'(CHANNELS - 1)) ? '0 : winner + 1'b1;
         end else begin
            state_d     = LOCKED;
            lock_chan_d = winner;
         end
      end
   end

   // Single output stage: load on transfer, drop valid on pop, otherwise hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_chan  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= pick_data;
         out_last  <= pick_last;
         out_chan  <= winner;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
